// File: rtl/crc32_stream.sv
// Multi-byte-per-cycle reflected CRC-32 over framed byte streams.
// A beat of up to DATA_BYTES lanes is folded each cycle; the final CRC lands in a one-entry result register.
module crc32_stream #(
  parameter int unsigned DATA_BYTES = 4,
  parameter logic [31:0] POLY       = 32'hEDB88320,
  parameter logic [31:0] INIT       = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT     = 32'hFFFFFFFF,
  parameter logic [31:0] RESIDUE    = 32'hDEBB20E3
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [8*DATA_BYTES-1:0]   i_data,
  input  logic [DATA_BYTES-1:0]     i_keep,
  input  logic                      i_last,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [31:0]               o_crc,
  output logic                      o_match
);

  // One byte through the reflected register, LSB of the byte first.
  function automatic logic [31:0] byte_step(input logic [31:0] crc_in, input logic [7:0] data_in);
    logic [31:0] c;
    c = crc_in;
    for (int b = 0; b < 8; b++) begin
      if (c[0] ^ data_in[b]) c = (c >> 1) ^ POLY;
      else                   c = c >> 1;
    end
    return c;
  endfunction

  logic [31:0] crc_reg;
  logic [31:0] crc_next;
  logic [31:0] result_reg;
  logic        match_reg;
  logic        valid_reg;
  logic        accept;

  logic [31:0] stage    [DATA_BYTES+1];
  logic        keep_run [DATA_BYTES];
  logic        lane_en  [DATA_BYTES];

  assign stage[0] = crc_reg;

  // keep_run[k] is set while lanes 0..k are all kept, so a hole in the mask
  // stops folding at the first cleared lane even if higher lanes are set.
  generate
    for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
      if (gi == 0) begin : g_first
        assign keep_run[gi] = i_keep[gi];
      end else begin : g_rest
        assign keep_run[gi] = keep_run[gi-1] & i_keep[gi];
      end
      assign lane_en[gi]    = !i_last || keep_run[gi];
      assign stage[gi+1]    = lane_en[gi] ? byte_step(stage[gi], i_data[8*gi +: 8]) : stage[gi];
    end
  endgenerate

  assign crc_next = stage[DATA_BYTES];
  assign o_ready  = !valid_reg || i_ready;
  assign accept   = i_valid && o_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      crc_reg    <= INIT;
      result_reg <= 32'h0;
      match_reg  <= 1'b0;
      valid_reg  <= 1'b0;
    end else begin
      if (valid_reg && i_ready) begin
        valid_reg <= 1'b0;
      end
      // A last beat loading in the same cycle as consumption keeps valid high.
      if (accept) begin
        if (i_last) begin
          crc_reg    <= INIT;
          result_reg <= crc_next ^ XOROUT;
          match_reg  <= (crc_next == RESIDUE);
          valid_reg  <= 1'b1;
        end else begin
          crc_reg    <= crc_next;
        end
      end
    end
  end

  assign o_valid = valid_reg;
  assign o_crc   = result_reg;
  assign o_match = match_reg;

endmodule
